// File: rtl/cdma_multi_rx_if.sv
// Bus bundle for cdma_multi_rx: the shared chip-sample stream, per-channel
// configuration, and the per-channel decision outputs.
// The driver of the sample stream uses the master modport; the receiver uses slave.
interface cdma_multi_rx_if #(
    parameter int NUM_USERS = 2,
    parameter int SAMPLE_W  = 8,
    parameter int LFSR_W    = 6,
    parameter int CODE_LEN  = 64
);
    localparam int ACC_W = SAMPLE_W + $clog2(CODE_LEN) + 1;

    logic signed [SAMPLE_W-1:0]     sample_in;
    logic                           sample_valid;
    logic                           sync;
    logic [NUM_USERS*LFSR_W-1:0]    user_seeds;
    logic [NUM_USERS-1:0]           user_enable;
    logic [NUM_USERS-1:0]           data_out;
    logic [NUM_USERS-1:0]           data_valid;
    logic [NUM_USERS-1:0]           sym_weak;
    logic [NUM_USERS*ACC_W-1:0]     corr_out;

    modport master (
        output sample_in, sample_valid, sync, user_seeds, user_enable,
        input  data_out, data_valid, sym_weak, corr_out
    );

    modport slave (
        input  sample_in, sample_valid, sync, user_seeds, user_enable,
        output data_out, data_valid, sym_weak, corr_out
    );
endinterface

// File: rtl/cdma_multi_rx.sv
// cdma_multi_rx: NUM_USERS parallel DSSS despreading correlators on one shared
// BPSK sample stream. Each channel multiplies the sample by its own LFSR chip
// (+1/-1), integrates over CODE_LEN valid chips and emits one decided bit.
// Optional feature macro: CDMA_RX_THRESH_EN adds a per-channel running
// magnitude average and flags symbols whose |corr| is below half of it.
module cdma_multi_rx #(
    parameter int                NUM_USERS = 2,
    parameter int                SAMPLE_W  = 8,
    parameter int                LFSR_W    = 6,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 6'b110000,
    parameter int                CODE_LEN  = 64
`ifdef CDMA_RX_THRESH_EN
    ,
    parameter int                AVG_SH    = 2
`endif
) (
    input  logic            clk,
    input  logic            rst,
    cdma_multi_rx_if.slave  bus
);
    localparam int ACC_W = SAMPLE_W + $clog2(CODE_LEN) + 1;
    localparam int CNT_W = $clog2(CODE_LEN);

    logic [CNT_W-1:0]        chip_cnt_q;
    logic                    last_chip;
    logic                    consume;
    logic signed [ACC_W-1:0] sample_ext;

    assign last_chip  = (chip_cnt_q == CNT_W'(CODE_LEN - 1));
    // sync wins over a coincident sample; that sample is simply lost
    assign consume    = bus.sample_valid && !bus.sync;
    assign sample_ext = {{(ACC_W-SAMPLE_W){bus.sample_in[SAMPLE_W-1]}}, bus.sample_in};

    // Shared chip position within the symbol, common to all channels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chip_cnt_q <= '0;
        end else if (bus.sync) begin
            chip_cnt_q <= '0;
        end else if (bus.sample_valid) begin
            chip_cnt_q <= last_chip ? '0 : chip_cnt_q + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_USERS; gi++) begin : g_ch
        logic [LFSR_W-1:0]       seed_raw;
        logic [LFSR_W-1:0]       seed_fix;
        logic [LFSR_W-1:0]       lfsr_q, lfsr_d;
        logic signed [ACC_W-1:0] acc_q, acc_d;
        logic signed [ACC_W-1:0] contrib;
        logic signed [ACC_W-1:0] final_sum;
        logic                    active_q, active_d;
        logic                    run;
        logic                    strobe;
        logic                    dout_q;
        logic                    dvalid_q;
        logic signed [ACC_W-1:0] corr_q;

        // An all-zero seed would lock the LFSR, so it is promoted to 1
        assign seed_raw  = bus.user_seeds[gi*LFSR_W +: LFSR_W];
        assign seed_fix  = (seed_raw == '0) ? LFSR_W'(1) : seed_raw;
        // A channel only joins at a symbol boundary (chip 0), never mid-symbol
        assign run       = bus.user_enable[gi] && (active_q || (chip_cnt_q == '0));
        assign contrib   = lfsr_q[LFSR_W-1] ? sample_ext : -sample_ext;
        assign final_sum = acc_q + contrib;
        assign strobe    = consume && last_chip && run;

        // Next state of the chip generator, integrator and participation flag
        always_comb begin
            lfsr_d   = lfsr_q;
            acc_d    = acc_q;
            active_d = active_q;
            if (bus.sync || !bus.user_enable[gi]) begin
                lfsr_d   = seed_fix;
                acc_d    = '0;
                active_d = 1'b0;
            end else if (bus.sample_valid) begin
                if (last_chip) begin
                    lfsr_d   = seed_fix;
                    acc_d    = '0;
                    active_d = 1'b0;
                end else if (run) begin
                    lfsr_d   = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
                    acc_d    = final_sum;
                    active_d = 1'b1;
                end
            end
        end

        // Correlator state registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lfsr_q   <= seed_fix;
                acc_q    <= '0;
                active_q <= 1'b0;
            end else begin
                lfsr_q   <= lfsr_d;
                acc_q    <= acc_d;
                active_q <= active_d;
            end
        end

        // Registered decision; data_out/corr_out hold between strobes
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q   <= 1'b0;
                dvalid_q <= 1'b0;
                corr_q   <= '0;
            end else begin
                dvalid_q <= strobe;
                if (strobe) begin
                    dout_q <= !final_sum[ACC_W-1] && (final_sum != '0);
                    corr_q <= final_sum;
                end
            end
        end

        assign bus.data_out[gi]                 = dout_q;
        assign bus.data_valid[gi]               = dvalid_q;
        assign bus.corr_out[gi*ACC_W +: ACC_W]  = corr_q;

`ifdef CDMA_RX_THRESH_EN
        logic signed [ACC_W:0] fin_x;
        logic signed [ACC_W:0] mag;
        logic signed [ACC_W:0] mag_avg_q;
        logic signed [ACC_W:0] mag_avg_d;
        logic                  weak_d;
        logic                  weak_q;

        assign fin_x     = {final_sum[ACC_W-1], final_sum};
        assign mag       = fin_x[ACC_W] ? -fin_x : fin_x;
        assign weak_d    = (mag < (mag_avg_q >>> 1));
        assign mag_avg_d = mag_avg_q + ((mag - mag_avg_q) >>> AVG_SH);

        // Running magnitude average; restarts from 0 whenever the channel is off
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mag_avg_q <= '0;
                weak_q    <= 1'b0;
            end else if (!bus.user_enable[gi]) begin
                mag_avg_q <= '0;
            end else if (strobe) begin
                mag_avg_q <= mag_avg_d;
                weak_q    <= weak_d;
            end
        end

        assign bus.sym_weak[gi] = weak_q;
`else
        assign bus.sym_weak[gi] = 1'b0;
`endif
    end
endmodule
